// File: rtl/multicycle_main_fsm.sv
// multicycle_main_fsm
//   Control FSM for a multi-cycle, shared-memory RV32I datapath. It sequences
//   fetch/decode/execute/writeback and drives the datapath mux selects and the
//   write strobes. ALU function decode stays outside this block.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   Op, Zero          opcode from the IR, ALU zero flag
//   MemReady          memory completes the current access this cycle
//   MemReq/MemWrite   memory request and write strobe
//   IRWrite, PCWrite  IR load, PC load (PCUpdate | Branch & Zero)
//   AdrSrc            memory address select (0: PC, 1: ALU result)
//   RegWrite          register file write
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc   datapath selects
//   Illegal           one-cycle pulse on an unsupported opcode in DECODE
//   State, InstrCount current state (debug), retired-instruction count
module multicycle_main_fsm #(
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter bit          EN_ITYPE      = 1'b1,
   parameter bit          EN_JAL        = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       Op,
   input  logic             Zero,
   input  logic             MemReady,
   output logic             MemReq,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             PCWrite,
   output logic             AdrSrc,
   output logic             RegWrite,
   output logic [1:0]       ResultSrc,
   output logic [1:0]       ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ImmSrc,
   output logic             Illegal,
   output logic [3:0]       State,
   output logic [CNT_W-1:0] InstrCount
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
   } state_t;

   // State-only outputs; registered alongside the state from the next state.
   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       reg_write;
      logic       branch;
      logic       pc_update;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
   } moore_t;

   function automatic moore_t moore_of(input state_t s);
      moore_t m;
      m = '0;
      case (s)
         S_FETCH: begin
            m.mem_req    = 1'b1;
            m.alu_src_b  = 2'b10;
            m.result_src = 2'b10;
         end
         S_DECODE: begin
            m.alu_src_a = 2'b01;
            m.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            m.alu_src_a = 2'b10;
            m.alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            m.mem_req = 1'b1;
            m.adr_src = 1'b1;
         end
         S_MEMWB: begin
            m.result_src = 2'b01;
            m.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            m.mem_req   = 1'b1;
            m.mem_write = 1'b1;
            m.adr_src   = 1'b1;
         end
         S_EXECR: begin
            m.alu_src_a = 2'b10;
            m.alu_op    = 2'b10;
         end
         S_EXECI: begin
            m.alu_src_a = 2'b10;
            m.alu_src_b = 2'b01;
            m.alu_op    = 2'b10;
         end
         S_ALUWB: m.reg_write = 1'b1;
         S_BEQ: begin
            m.alu_src_a = 2'b10;
            m.alu_op    = 2'b01;
            m.branch    = 1'b1;
         end
         S_JAL: begin
            m.alu_src_a = 2'b01;
            m.alu_src_b = 2'b10;
            m.pc_update = 1'b1;
         end
         default: m = '0;
      endcase
      return m;
   endfunction

   state_t           state;
   state_t           next_state;
   moore_t           moore;
   logic [CNT_W-1:0] count;
   logic             ready;
   logic             supported;
   logic             retire;

   assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

   always_comb begin
      supported = 1'b0;
      case (Op)
         OP_LW, OP_SW, OP_R, OP_BEQ: supported = 1'b1;
         OP_I:                       supported = EN_ITYPE;
         OP_JAL:                     supported = EN_JAL;
         default:                    supported = 1'b0;
      endcase
   end

   always_comb begin
      next_state = S_FETCH;
      retire     = 1'b0;
      case (state)
         S_FETCH:  next_state = ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            next_state = S_FETCH;
            if (supported) begin
               case (Op)
                  OP_LW, OP_SW: next_state = S_MEMADR;
                  OP_R:         next_state = S_EXECR;
                  OP_I:         next_state = S_EXECI;
                  OP_BEQ:       next_state = S_BEQ;
                  OP_JAL:       next_state = S_JAL;
                  default:      next_state = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  next_state = (Op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD: next_state = ready ? S_MEMWB : S_MEMREAD;
         S_MEMWRITE: begin
            next_state = ready ? S_FETCH : S_MEMWRITE;
            retire     = ready;
         end
         S_EXECR, S_EXECI, S_JAL: next_state = S_ALUWB;
         S_MEMWB, S_ALUWB, S_BEQ: begin
            next_state = S_FETCH;
            retire     = 1'b1;
         end
         default: next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         moore <= moore_of(S_FETCH);
         count <= '0;
      end else begin
         state <= next_state;
         moore <= moore_of(next_state);
         if (retire) count <= count + CNT_W'(1);
      end
   end

   // Strobes are gated by rst so a reset mid-access drops them without a clock edge.
   always_comb begin
      MemReq    = moore.mem_req   & ~rst;
      MemWrite  = moore.mem_write & ~rst;
      RegWrite  = moore.reg_write & ~rst;
      IRWrite   = (state == S_FETCH) & ready & ~rst;
      PCWrite   = (((state == S_FETCH) & ready) | moore.pc_update
                   | (moore.branch & Zero)) & ~rst;
      Illegal   = (state == S_DECODE) & ~supported & ~rst;
      AdrSrc    = moore.adr_src;
      ResultSrc = moore.result_src;
      ALUSrcA   = moore.alu_src_a;
      ALUSrcB   = moore.alu_src_b;
      ALUOp     = moore.alu_op;
      State     = state;
      InstrCount = count;
   end

   always_comb begin
      case (Op)
         OP_SW:   ImmSrc = 2'b01;
         OP_BEQ:  ImmSrc = 2'b10;
         OP_JAL:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

endmodule
